// File: rtl/pixel_unpacker_pkg.sv
// Shared vision-pipeline defaults and the packed-word width helper.
package pixel_unpacker_pkg;

    localparam int DEF_PIX_W        = 8;
    localparam int DEF_PIX_PER_WORD = 4;
    localparam int DEF_LINE_LEN     = 640;

    function automatic int word_w(input int pix_w, input int pix_per_word);
        return pix_w * pix_per_word;
    endfunction

endpackage

// File: rtl/pixel_unpacker_if.sv
// Word-in / pixel-out bundle; master drives words and controls, slave is the unpacker.
interface pixel_unpacker_if
    import pixel_unpacker_pkg::*;
#(
    parameter int PIX_W        = DEF_PIX_W,
    parameter int PIX_PER_WORD = DEF_PIX_PER_WORD
);

    logic [word_w(PIX_W, PIX_PER_WORD)-1:0] word_in;
    logic                                   word_valid;
    logic                                   word_ready;
    logic                                   stall;
    logic                                   flush;
    logic [PIX_W-1:0]                       pix_out;
    logic                                   pix_en;
    logic                                   pix_sol;
    logic                                   pix_eol;
    logic                                   busy;

    modport master (
        output word_in, word_valid, stall, flush,
        input  word_ready, pix_out, pix_en, pix_sol, pix_eol, busy
    );

    modport slave (
        input  word_in, word_valid, stall, flush,
        output word_ready, pix_out, pix_en, pix_sol, pix_eol, busy
    );

endinterface

// File: rtl/pixel_col_counter.sv
// Column counter wrapping at LINE_LEN-1; flags first/last column of the current position.
// Advances one step per enabled edge; sync clear beats enable.
module pixel_col_counter
    import pixel_unpacker_pkg::*;
#(
    parameter int LINE_LEN = DEF_LINE_LEN
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic first,
    output logic last
);

    localparam int            CW       = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(LINE_LEN - 1);

    logic [CW-1:0] col;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col <= '0;
        end else if (clr) begin
            col <= '0;
        end else if (en) begin
            col <= (col == COL_LAST) ? '0 : col + CW'(1);
        end
    end

    assign first = (col == '0);
    assign last  = (col == COL_LAST);

endmodule

// File: rtl/pixel_unpacker.sv
// Unpacks words into one registered pixel per cycle with SOL/EOL markers; 2 edges accept->pix_en.
// Two-deep word buffer (pend, cur); word_ready drops while pend is occupied or flush is high.
module pixel_unpacker
    import pixel_unpacker_pkg::*;
#(
    parameter int PIX_W        = DEF_PIX_W,
    parameter int PIX_PER_WORD = DEF_PIX_PER_WORD,
    parameter int LINE_LEN     = DEF_LINE_LEN
) (
    input  logic             clk,
    input  logic             reset,
    pixel_unpacker_if.slave  bus
);

    localparam int                WORD_W    = word_w(PIX_W, PIX_PER_WORD);
    localparam int                SLOT_W    = $clog2(PIX_PER_WORD);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(PIX_PER_WORD - 1);

    logic [WORD_W-1:0] pend;
    logic [WORD_W-1:0] cur;
    logic              pend_v;
    logic              cur_v;
    logic [SLOT_W-1:0] slot;
    logic [PIX_W-1:0]  pix_q;
    logic              en_q;
    logic              sol_q;
    logic              eol_q;
    logic              col_first;
    logic              col_last;

    logic              accept;
    logic              emit;
    logic              last_slot;
    logic              xfer;
    logic [PIX_W-1:0]  slot_pix;

    assign bus.word_ready = ~pend_v & ~bus.flush & ~reset;

    // Flush outranks everything, so it gates emission and transfer here rather than in the registers.
    always_comb begin
        accept    = bus.word_valid & bus.word_ready;
        emit      = cur_v & ~bus.stall & ~bus.flush;
        last_slot = emit & (slot == SLOT_LAST);
        xfer      = pend_v & ~bus.flush & (~cur_v | last_slot);
        slot_pix  = cur[int'(slot)*PIX_W +: PIX_W];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend   <= '0;
            pend_v <= 1'b0;
            cur    <= '0;
            cur_v  <= 1'b0;
            slot   <= '0;
        end else if (bus.flush) begin
            pend_v <= 1'b0;
            cur_v  <= 1'b0;
            slot   <= '0;
        end else begin
            // accept needs pend empty and xfer needs it full, so the two never coincide.
            if (accept) begin
                pend   <= bus.word_in;
                pend_v <= 1'b1;
            end else if (xfer) begin
                pend_v <= 1'b0;
            end

            if (xfer) begin
                cur   <= pend;
                cur_v <= 1'b1;
            end else if (last_slot) begin
                cur_v <= 1'b0;
            end

            if (emit) begin
                slot <= last_slot ? '0 : slot + SLOT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_q <= '0;
            en_q  <= 1'b0;
            sol_q <= 1'b0;
            eol_q <= 1'b0;
        end else if (emit) begin
            pix_q <= slot_pix;
            en_q  <= 1'b1;
            sol_q <= col_first;
            eol_q <= col_last;
        end else begin
            en_q  <= 1'b0;
            sol_q <= 1'b0;
            eol_q <= 1'b0;
        end
    end

    pixel_col_counter #(
        .LINE_LEN (LINE_LEN)
    ) u_col (
        .clk   (clk),
        .reset (reset),
        .en    (emit),
        .clr   (bus.flush),
        .first (col_first),
        .last  (col_last)
    );

    assign bus.pix_out = pix_q;
    assign bus.pix_en  = en_q;
    assign bus.pix_sol = sol_q;
    assign bus.pix_eol = eol_q;
    assign bus.busy    = cur_v | pend_v;

endmodule

// File: tb/tb_pixel_unpacker.sv
// Directed bench for pixel_unpacker with a 6-pixel line so wraps occur inside words.
module tb_pixel_unpacker;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int n_assert = 0;
    int n_fail   = 0;

    pixel_unpacker_if #(.PIX_W(8), .PIX_PER_WORD(4)) bus ();

    pixel_unpacker #(
        .PIX_W        (8),
        .PIX_PER_WORD (4),
        .LINE_LEN     (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pix(input string tag, input logic [7:0] p, input logic sol, input logic eol);
        chk({tag, "_en"},  32'(bus.pix_en),  32'd1);
        chk({tag, "_pix"}, 32'(bus.pix_out), 32'(p));
        chk({tag, "_sol"}, 32'(bus.pix_sol), 32'(sol));
        chk({tag, "_eol"}, 32'(bus.pix_eol), 32'(eol));
    endtask

    task automatic chk_idle(input string tag, input logic [7:0] p);
        chk({tag, "_en"},  32'(bus.pix_en),  32'd0);
        chk({tag, "_pix"}, 32'(bus.pix_out), 32'(p));
        chk({tag, "_sol"}, 32'(bus.pix_sol), 32'd0);
        chk({tag, "_eol"}, 32'(bus.pix_eol), 32'd0);
    endtask

    logic [31:0] words [3];
    logic [7:0]  exp_p [12];
    logic        exp_sol [12];
    logic        exp_eol [12];
    int          acc_cyc [3];
    logic        acc;
    int          wi;
    int          k;
    bit          started;

    initial begin
        words   = '{32'h88776655, 32'hCCBBAA99, 32'h00FFEEDD};
        exp_p   = '{8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h00};
        exp_sol = '{0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        exp_eol = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        acc_cyc = '{0, 0, 0};

        bus.word_in    = '0;
        bus.word_valid = 1'b0;
        bus.stall      = 1'b0;
        bus.flush      = 1'b0;

        // Reset phase
        #1;
        chk_idle("rst", 8'h00);
        chk("rst_busy",  32'(bus.busy),       32'd0);
        chk("rst_ready", 32'(bus.word_ready), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rel_ready", 32'(bus.word_ready), 32'd1);
        chk("rel_busy",  32'(bus.busy),       32'd0);

        // Single word, cols 0..3
        bus.word_in    = 32'h44332211;
        bus.word_valid = 1'b1;
        tick();
        bus.word_valid = 1'b0;
        chk("w1_busy",  32'(bus.busy),       32'd1);
        chk("w1_ready", 32'(bus.word_ready), 32'd0);
        chk("w1_en_e1", 32'(bus.pix_en),     32'd0);
        tick();
        chk("w1_en_e2", 32'(bus.pix_en),     32'd0);
        chk("w1_rdy_e2", 32'(bus.word_ready), 32'd1);
        tick(); chk_pix("w1_p0", 8'h11, 1'b1, 1'b0);
        tick(); chk_pix("w1_p1", 8'h22, 1'b0, 1'b0);
        tick(); chk_pix("w1_p2", 8'h33, 1'b0, 1'b0);
        tick(); chk_pix("w1_p3", 8'h44, 1'b0, 1'b0);
        chk("w1_busy_end", 32'(bus.busy), 32'd0);
        tick(); chk_idle("w1_after", 8'h44);

        // Back-to-back stream starting at col 4
        wi = 0;
        k = 0;
        started = 1'b0;
        bus.word_in    = words[0];
        bus.word_valid = 1'b1;
        for (int c = 0; c < 40 && k < 12; c++) begin
            acc = bus.word_valid & bus.word_ready;
            tick();
            if (acc) begin
                acc_cyc[wi] = c;
                wi++;
                if (wi < 3) bus.word_in = words[wi];
                else        bus.word_valid = 1'b0;
            end
            chk("str_qual", 32'((bus.pix_sol | bus.pix_eol) & ~bus.pix_en), 32'd0);
            if (bus.pix_en) begin
                chk("str_pix", 32'(bus.pix_out), 32'(exp_p[k]));
                chk("str_sol", 32'(bus.pix_sol), 32'(exp_sol[k]));
                chk("str_eol", 32'(bus.pix_eol), 32'(exp_eol[k]));
                k++;
                started = 1'b1;
            end else if (started) begin
                chk("str_gap", 32'(bus.pix_en), 32'd1);
            end
        end
        bus.word_valid = 1'b0;
        chk("str_count",  32'(k),  32'd12);
        chk("str_accepts", 32'(wi), 32'd3);
        chk("str_space01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd2);
        chk("str_space12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd4);
        tick(); chk_idle("str_after", 8'h00);

        // Stall mid-word, col 4; a word arrives into empty pend during the stall
        bus.word_in    = 32'h44332211;
        bus.word_valid = 1'b1;
        tick();
        bus.word_valid = 1'b0;
        tick();
        tick(); chk_pix("st_p0", 8'h11, 1'b0, 1'b0);
        tick(); chk_pix("st_p1", 8'h22, 1'b0, 1'b1);
        bus.stall      = 1'b1;
        bus.word_in    = 32'hDDCCBBAA;
        bus.word_valid = 1'b1;
        tick(); chk_idle("st_h0", 8'h22);
        chk("st_pend_full", 32'(bus.word_ready), 32'd0);
        bus.word_valid = 1'b0;
        tick(); chk_idle("st_h1", 8'h22);
        tick(); chk_idle("st_h2", 8'h22);
        chk("st_busy", 32'(bus.busy), 32'd1);
        bus.stall = 1'b0;
        tick(); chk_pix("st_p2", 8'h33, 1'b1, 1'b0);
        tick(); chk_pix("st_p3", 8'h44, 1'b0, 1'b0);
        tick(); chk_pix("st_q0", 8'hAA, 1'b0, 1'b0);
        tick(); chk_pix("st_q1", 8'hBB, 1'b0, 1'b0);
        tick(); chk_pix("st_q2", 8'hCC, 1'b0, 1'b0);
        tick(); chk_pix("st_q3", 8'hDD, 1'b0, 1'b1);
        tick(); chk_idle("st_after", 8'hDD);
        chk("st_busy_end", 32'(bus.busy), 32'd0);

        // Flush with cur half-consumed and pend full
        bus.word_in    = 32'h04030201;
        bus.word_valid = 1'b1;
        tick();
        bus.word_in    = 32'h08070605;
        tick();
        tick(); chk_pix("fl_p0", 8'h01, 1'b1, 1'b0);
        bus.word_valid = 1'b0;
        tick(); chk_pix("fl_p1", 8'h02, 1'b0, 1'b0);
        chk("fl_pend_full", 32'(bus.word_ready), 32'd0);
        bus.flush      = 1'b1;
        bus.word_in    = 32'h0C0B0A09;
        bus.word_valid = 1'b1;
        #1;
        chk("fl_ready", 32'(bus.word_ready), 32'd0);
        tick(); chk_idle("fl_edge", 8'h02);
        chk("fl_busy", 32'(bus.busy), 32'd0);
        bus.flush      = 1'b0;
        bus.word_valid = 1'b0;
        #1;
        chk("fl_ready_after", 32'(bus.word_ready), 32'd1);
        tick(); chk_idle("fl_quiet", 8'h02);
        chk("fl_not_acc", 32'(bus.busy), 32'd0);
        bus.word_valid = 1'b1;
        tick();
        bus.word_valid = 1'b0;
        tick();
        tick(); chk_pix("fl_r0", 8'h09, 1'b1, 1'b0);
        tick(); chk_pix("fl_r1", 8'h0A, 1'b0, 1'b0);

        // Async reset between edges, mid-word
        #2;
        reset = 1'b1;
        #1;
        chk_idle("ar", 8'h00);
        chk("ar_busy",  32'(bus.busy),       32'd0);
        chk("ar_ready", 32'(bus.word_ready), 32'd0);
        #2;
        reset = 1'b0;
        bus.word_in    = 32'h14131211;
        bus.word_valid = 1'b1;
        tick();
        bus.word_valid = 1'b0;
        tick();
        tick(); chk_pix("ar_p0", 8'h11, 1'b1, 1'b0);
        tick(); chk_pix("ar_p1", 8'h12, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed no completion, expected finish before 50000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pixel_unpacker.md
Name: pixel_unpacker

Overview:
- Reads packed pixel words from an upstream word source over a valid/ready handshake.
- Emits them one pixel per cycle as a registered pixel plus a single-cycle enable strobe.
- The strobe is the write-enable consumed by downstream enable registers and pixel pipelines.
- Also generates start-of-line and end-of-line markers from an internal column counter.

Parameters:
- PIX_W, 8, bits per pixel
- PIX_PER_WORD, 4, pixels packed per input word, >=2; pixel 0 in the LSBs
- LINE_LEN, 640, pixels per video line, >=2; need not be a multiple of PIX_PER_WORD

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- word_in  in  PIX_W*PIX_PER_WORD  packed pixel word
- word_valid  in  1  word_in is valid
- word_ready  out  1  block accepts word this cycle
- stall  in  1  downstream hold; no pixel is emitted while high
- flush  in  1  synchronous clear: drops buffered data and restarts the line
- pix_out  out  PIX_W  current pixel, registered
- pix_en  out  1  one-cycle strobe: pix_out is new this cycle
- pix_sol  out  1  qualifies pix_en: first pixel of a line
- pix_eol  out  1  qualifies pix_en: last pixel of a line
- busy  out  1  any word buffered

Behaviour:
- Reset (async, active-high): all registers return to 0.
  - Outputs during and after reset: pix_out=0, pix_en=0, pix_sol=0, pix_eol=0, busy=0.
  - word_ready=0 while reset is asserted; word_ready=1 in the first cycle after release.
- Storage: pending word register (pend, pend_v), current word register (cur, cur_v), slot counter (0..PIX_PER_WORD-1), column counter (0..LINE_LEN-1).
- Handshake:
  - word_ready = !pend_v & !flush & !reset (combinational).
  - A word is accepted at a clock edge where word_valid & word_ready: pend<=word_in, pend_v<=1.
  - word_in may change freely when the word is not accepted.
- Transfer: cur is loaded from pend (pend_v cleared) at an edge where pend_v is set and either:
  - cur_v=0, or
  - the last slot of cur is emitted at that same edge.
- Emit: at each edge with cur_v & !stall:
  - pix_out<=cur[slot*PIX_W +: PIX_W], pix_en<=1;
  - pix_sol<=(col==0), pix_eol<=(col==LINE_LEN-1);
  - col wraps to 0 after LINE_LEN-1, else increments;
  - slot increments; at slot PIX_PER_WORD-1, slot<=0 and cur_v<=0 unless reloaded from pend.
- Otherwise (stall, or cur_v=0): pix_en, pix_sol and pix_eol are 0 next cycle; pix_out, slot and col hold.
- Latency: word accepted at edge k → loaded into cur at edge k+1 (if cur free) → first pixel_en high after edge k+2.
- Throughput: sustained 1 pixel/cycle when the source offers a word at least every PIX_PER_WORD cycles.
- Back-pressure: with cur and pend both full, word_ready=0 until the transfer edge.
- Stall: stall only affects emission.
  - A word can still be accepted into an empty pend.
  - No pend→cur transfer occurs while cur is partially consumed.
- Flush (synchronous, highest priority): at the edge, pend_v=cur_v=0, slot=0, col=0, pix_en=pix_sol=pix_eol=0.
  - Any word offered in the same cycle is not accepted.
  - pix_out holds its value.
- Line wrap inside a word: col wraps mid-word. pix_eol and the next pix_sol can come from the same word in consecutive cycles.
- busy = cur_v | pend_v.

Decomposition:
- Shared vision package holds the default PIX_W, the packed-word width function (PIX_W*PIX_PER_WORD) and the default LINE_LEN.
- One natural sub-module, pixel_col_counter:
  - wrap counter with enable, sync clear and async reset;
  - outputs col==0 and col==LINE_LEN-1.
- The remainder (buffer, slot mux, handshake) stays in pixel_unpacker.

Test Plan:
- Reset release, then one word 0x44332211 accepted at edge 1, stall=0 → pix_en high for 4 consecutive cycles starting after edge 3. pix_out sequence is 0x11,0x22,0x33,0x44; pix_sol high on the first pixel only; busy drops after the last pixel.
- Back-to-back words offered continuously → word_ready toggles so that pix_en stays high continuously with no gaps; exactly one word is accepted per 4 cycles.
- stall held high for 3 cycles mid-word (after pixel 0x22) → pix_en low for exactly 3 cycles, then 0x33,0x44 resume. pix_out stays 0x22 during the stall, and no data is lost or duplicated.
- LINE_LEN=6, three words streamed → pix_eol on pixel 6 (second pixel of word 2) and pix_sol on pixel 7; col wraps correctly, and pix_sol/pix_eol are never high without pix_en.
- flush asserted while cur holds a half-consumed word and pend is full, word_valid=1 in the same cycle → no further pix_en, busy=0 after the edge, word not accepted. The next word restarts with pix_sol on its first pixel.
- Async reset asserted mid-word, between clock edges → pix_en, pix_out and busy go to 0 immediately. After release, the first accepted word emits from slot 0 with pix_sol=1.
